secuenciador_fir_trunc: RTL and testbench
=========================================

# secuenciador_fir_trunc

Control and datapath sequencer for the fixed-point filter chain. It captures each new signed sample into a TAPS-deep delay line, then runs one multiply-accumulate per clock over all taps. Coefficients are read through an address port. It then truncates the wide accumulator to an N-bit result and pulses a valid strobe. It sits between the sample source and the result writer, and replaces the free-running combinational sum→truncation path with a scheduled, one-sample-at-a-time pipeline.

## Interface
- N, 24: sample, coefficient and output width (two's complement)
- TAPS, 8: filter length; power of two, 2..64
- FRAC, 16: fractional bits of samples and coefficients (Q(N-FRAC).FRAC)
- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock; reset is synchronous and active-high
- Dato_Listo  in  1  new-sample strobe, sampled on CLK
- Datos_In  in  N  signed sample, valid while Dato_Listo=1
- Coef  in  N  signed coefficient for Dir_Coef, combinational response same cycle
- Dir_Coef  out  log2(TAPS)  coefficient address
- Ocupado  out  1  high whenever state ≠ IDLE
- Datos_Trunc  out  N  truncated result, held until next result
- Dato_Valido  out  1  one-cycle pulse when Datos_Trunc updates
- Overflow  out  1  registered with Datos_Trunc; result exceeded N-bit range
- Perdido  out  1  sticky: a Dato_Listo arrived while Ocupado

## Operation
- States: IDLE, MAC, TRUNC.
- IDLE: on Dato_Listo=1:
  - shift Datos_In into delay line slot 0; older samples move up one slot and slot TAPS-1 is discarded
  - clear the accumulator, set idx=0, go to MAC
- MAC:
  - Dir_Coef=idx
  - acc += x[idx]·Coef, a full 2N-bit signed product added into an accumulator of width 2N+log2(TAPS)
  - idx increments each cycle; after idx=TAPS-1 is accumulated, go to TRUNC
- TRUNC:
  - Datos_Trunc ← acc[FRAC+N-1:FRAC], discarding the low FRAC bits with no rounding (floor)
  - Overflow ← 1 if acc[MSB:FRAC+N-1] are not all equal
  - Dato_Valido=1 for this cycle; return to IDLE
- Dato_Listo while Ocupado: the sample is dropped, the delay line is untouched and Perdido is set; Perdido clears only on RST.
- Dato_Listo in the same cycle that TRUNC returns to IDLE is a dropped sample (Ocupado is still 1).
- Dir_Coef=0 while in IDLE and TRUNC.

## Timing
- Reset values:
  - state IDLE, all delay-line slots 0, acc 0, idx 0
  - Datos_Trunc 0, Dato_Valido 0, Overflow 0, Perdido 0, Ocupado 0, Dir_Coef 0
- RST mid-operation: same-edge return to the reset values; the partial result is lost and no Dato_Valido is produced.
- Capture edge k (IDLE, Dato_Listo=1) → MAC accumulates on edges k+1..k+TAPS → Datos_Trunc/Overflow update and Dato_Valido rises on edge k+TAPS+1.
- Latency TAPS+1 clocks; minimum sample spacing TAPS+2 clocks (default 10).
- Dato_Valido is high for exactly one cycle; Datos_Trunc is stable from that edge until the next result.
- Coef must settle within the cycle Dir_Coef is presented; there is no coefficient wait state.

## Configuration
- SATURACION_TRUNC_EN defined:
  - on overflow, Datos_Trunc clamps to 2^(N-1)-1 (0x7FFFFF) when acc is positive, or -2^(N-1) (0x800000) when negative
  - Overflow still pulses with the result
- Undefined: plain bit-select wrap-around; Overflow is still reported.

## Test plan
- Reset, then all Coef=0x010000 (1.0); samples 0x010000 ×8 at 10-clock spacing → eighth result Datos_Trunc=0x080000, Overflow=0; Dato_Valido exactly 9 clocks after each capture edge.
- Impulse 0x010000 then seven zeros, Coef[k]=k·0x001000 → successive outputs 0x000000, 0x001000, …, 0x007000.
- Negative floor: single sample 0xFFFFFF (-2^-16), Coef[0]=0x008000 (0.5), others 0 → Datos_Trunc=0xFFFFFF (floor, not 0).
- All samples and coefficients 0x7FFFFF → Overflow=1; Datos_Trunc=0x7FFFFF with SATURACION_TRUNC_EN, the wrapped bit-select value without it.
- Dato_Listo pulsed 3 clocks after a capture → sample ignored, Perdido=1 and held; the current result is unaffected.
- RST asserted at MAC idx=4 → next cycle all outputs at reset values, no Dato_Valido; a new capture afterwards yields a correct result from a zeroed delay line.

Source files
------------

// File: rtl/secuenciador_fir_trunc.sv
`default_nettype none
// ============================================================================
// Module   : secuenciador_fir_trunc
// Brief    : Sequenced FIR. Captures one sample, runs TAPS serial MACs, then
//            floor-truncates the accumulator to N bits and pulses a valid strobe.
//            Optional macro SATURACION_TRUNC_EN clamps the result on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module secuenciador_fir_trunc #(
    parameter int N    = 24,
    parameter int TAPS = 8,
    parameter int FRAC = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Dato_Listo,
    input  logic [N-1:0]             Datos_In,
    input  logic [N-1:0]             Coef,
    output logic [$clog2(TAPS)-1:0]  Dir_Coef,
    output logic                     Ocupado,
    output logic [N-1:0]             Datos_Trunc,
    output logic                     Dato_Valido,
    output logic                     Overflow,
    output logic                     Perdido
);

    localparam int C_IDX_W = $clog2(TAPS);
    localparam int C_ACC_W = 2 * N + C_IDX_W;
    localparam int C_TOP_W = C_ACC_W - FRAC - N + 1;
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        TRUNC = 2'd2
    } state_t;

    state_t                state_q;
    logic signed [N-1:0]   x_q [TAPS];
    logic [C_ACC_W-1:0]    acc_q;
    logic [C_IDX_W-1:0]    idx_q;
    logic [N-1:0]          trunc_q;
    logic                  valido_q;
    logic                  ovf_q;
    logic                  perdido_q;
    logic                  ocupado_q;

    logic signed [2*N-1:0] prod;
    logic [C_ACC_W-1:0]    acc_d;
    logic [C_TOP_W-1:0]    acc_top;
    logic                  ovf_d;
    logic [N-1:0]          trunc_d;

    assign prod    = x_q[idx_q] * $signed(Coef);
    assign acc_d   = acc_q + {{C_IDX_W{prod[2*N-1]}}, prod};
    // Result fits in N bits only when every bit from the result MSB upward is a copy of the sign.
    assign acc_top = acc_q[C_ACC_W-1:FRAC+N-1];
    assign ovf_d   = ~((&acc_top) | ~(|acc_top));

`ifdef SATURACION_TRUNC_EN
    assign trunc_d = ovf_d ? (acc_q[C_ACC_W-1] ? {1'b1, {(N-1){1'b0}}}
                                               : {1'b0, {(N-1){1'b1}}})
                           : acc_q[FRAC+N-1:FRAC];
`else
    assign trunc_d = acc_q[FRAC+N-1:FRAC];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
            acc_q     <= '0;
            idx_q     <= '0;
            trunc_q   <= '0;
            valido_q  <= 1'b0;
            ovf_q     <= 1'b0;
            perdido_q <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            valido_q <= 1'b0;
            if (Dato_Listo && state_q != IDLE) begin
                perdido_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (Dato_Listo) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            x_q[i] <= x_q[i-1];
                        end
                        x_q[0]    <= Datos_In;
                        acc_q     <= '0;
                        idx_q     <= '0;
                        ocupado_q <= 1'b1;
                        state_q   <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    // Wraps back to zero after the last tap, leaving Dir_Coef at 0 in TRUNC.
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == C_IDX_LAST) begin
                        state_q <= TRUNC;
                    end
                end
                TRUNC: begin
                    trunc_q   <= trunc_d;
                    ovf_q     <= ovf_d;
                    valido_q  <= 1'b1;
                    ocupado_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign Dir_Coef    = idx_q;
    assign Ocupado     = ocupado_q;
    assign Datos_Trunc = trunc_q;
    assign Dato_Valido = valido_q;
    assign Overflow    = ovf_q;
    assign Perdido     = perdido_q;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_fir_trunc.sv
`default_nettype none
// ============================================================================
// Module   : tb_secuenciador_fir_trunc
// Brief    : Directed table-driven bench for secuenciador_fir_trunc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_secuenciador_fir_trunc;

    logic        CLK;
    logic        RST;
    logic        Dato_Listo;
    logic [23:0] Datos_In;
    logic [23:0] Coef;
    logic [2:0]  Dir_Coef;
    logic        Ocupado;
    logic [23:0] Datos_Trunc;
    logic        Dato_Valido;
    logic        Overflow;
    logic        Perdido;

    logic [23:0] coef_mem [8];

    int checks;
    int errors;

    typedef struct {
        logic        rst_before;
        int          mode;
        logic [23:0] sample;
        logic [23:0] exp_trunc;
        logic        exp_ovf;
        int          pulse_at;
        logic [23:0] pulse_smp;
        logic        exp_perd;
    } vec_t;

    vec_t tv [40];
    int   nv;

    secuenciador_fir_trunc #(.N(24), .TAPS(8), .FRAC(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Dato_Listo  (Dato_Listo),
        .Datos_In    (Datos_In),
        .Coef        (Coef),
        .Dir_Coef    (Dir_Coef),
        .Ocupado     (Ocupado),
        .Datos_Trunc (Datos_Trunc),
        .Dato_Valido (Dato_Valido),
        .Overflow    (Overflow),
        .Perdido     (Perdido)
    );

    assign Coef = coef_mem[Dir_Coef];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rb, input int mode, input logic [23:0] s,
                       input logic [23:0] e, input logic eo, input int pat,
                       input logic [23:0] ps, input logic ep);
        tv[nv].rst_before = rb;
        tv[nv].mode       = mode;
        tv[nv].sample     = s;
        tv[nv].exp_trunc  = e;
        tv[nv].exp_ovf    = eo;
        tv[nv].pulse_at   = pat;
        tv[nv].pulse_smp  = ps;
        tv[nv].exp_perd   = ep;
        nv++;
    endtask

    task automatic set_coef(input int mode);
        for (int k = 0; k < 8; k++) begin
            case (mode)
                0:       coef_mem[k] = 24'h010000;
                1:       coef_mem[k] = 24'(k * 32'h1000);
                2:       coef_mem[k] = (k == 0) ? 24'h008000 : 24'h000000;
                default: coef_mem[k] = 24'h7FFFFF;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Capture one sample, optionally pulse a second strobe sampled pat edges after capture.
    task automatic do_sample(input logic [23:0] s, input int pat, input logic [23:0] ps,
                             output logic [23:0] res, output logic ovf, output int lat,
                             output logic one_cycle);
        logic got;
        @(negedge CLK);
        Dato_Listo = 1'b1;
        Datos_In   = s;
        @(posedge CLK);
        #1;
        Dato_Listo = 1'b0;
        lat = 0;
        got = 1'b0;
        if (pat == 1) begin
            Dato_Listo = 1'b1;
            Datos_In   = ps;
        end
        while (!got && lat < 20) begin
            @(posedge CLK);
            #1;
            Dato_Listo = 1'b0;
            lat++;
            if (Dato_Valido) got = 1'b1;
            if (lat + 1 == pat) begin
                Dato_Listo = 1'b1;
                Datos_In   = ps;
            end
        end
        res = Datos_Trunc;
        ovf = Overflow;
        @(posedge CLK);
        #1;
        one_cycle = got && !Dato_Valido && (Datos_Trunc === res);
    endtask

    initial begin
        logic [23:0] res;
        logic        ovf;
        int          lat;
        logic        one_cycle;
        logic [31:0] tmp;
        logic [23:0] e;
        int          pulses;

        checks     = 0;
        errors     = 0;
        nv         = 0;
        RST        = 1'b0;
        Dato_Listo = 1'b0;
        Datos_In   = '0;
        set_coef(0);

        for (int n = 1; n <= 8; n++) begin
            add(n == 1, 0, 24'h010000, 24'(n * 32'h10000), 1'b0, 0, 24'h0, 1'b0);
        end
        add(1'b1, 1, 24'h010000, 24'h000000, 1'b0, 0, 24'h0, 1'b0);
        for (int n = 1; n < 8; n++) begin
            add(1'b0, 1, 24'h000000, 24'(n * 32'h1000), 1'b0, 0, 24'h0, 1'b0);
        end
        add(1'b1, 2, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 0, 24'h0, 1'b0);
        for (int n = 1; n <= 8; n++) begin
`ifdef SATURACION_TRUNC_EN
            e = 24'h7FFFFF;
`else
            tmp = 32'h0100_0000 - 32'(n * 256);
            e   = tmp[23:0];
`endif
            add(n == 1, 3, 24'h7FFFFF, e, 1'b1, 0, 24'h0, 1'b0);
        end
        add(1'b1, 0, 24'h010000, 24'h010000, 1'b0, 3, 24'h050000, 1'b1);
        add(1'b0, 0, 24'h010000, 24'h020000, 1'b0, 0, 24'h0,     1'b1);
        add(1'b0, 0, 24'h010000, 24'h030000, 1'b0, 9, 24'h070000, 1'b1);
        add(1'b0, 0, 24'h010000, 24'h040000, 1'b0, 0, 24'h0,     1'b1);

        do_reset();
        chk("rst_trunc",   {8'h0, Datos_Trunc}, 32'h0);
        chk("rst_valid",   {31'h0, Dato_Valido}, 32'h0);
        chk("rst_ovf",     {31'h0, Overflow}, 32'h0);
        chk("rst_perdido", {31'h0, Perdido}, 32'h0);
        chk("rst_ocupado", {31'h0, Ocupado}, 32'h0);
        chk("rst_dir",     {29'h0, Dir_Coef}, 32'h0);

        for (int i = 0; i < nv; i++) begin
            set_coef(tv[i].mode);
            if (tv[i].rst_before) do_reset();
            do_sample(tv[i].sample, tv[i].pulse_at, tv[i].pulse_smp, res, ovf, lat, one_cycle);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd9);
            chk($sformatf("v%0d_trunc", i), {8'h0, res}, {8'h0, tv[i].exp_trunc});
            chk($sformatf("v%0d_ovf", i), {31'h0, ovf}, {31'h0, tv[i].exp_ovf});
            chk($sformatf("v%0d_pulse1", i), {31'h0, one_cycle}, 32'h1);
            chk($sformatf("v%0d_perdido", i), {31'h0, Perdido}, {31'h0, tv[i].exp_perd});
        end

        // Reset in the middle of the MAC sweep, with idx=4 on the coefficient port.
        @(negedge CLK);
        Dato_Listo = 1'b1;
        Datos_In   = 24'h030000;
        @(posedge CLK);
        #1;
        Dato_Listo = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("mid_dir4",    {29'h0, Dir_Coef}, 32'h4);
        chk("mid_ocupado", {31'h0, Ocupado}, 32'h1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("mr_trunc",   {8'h0, Datos_Trunc}, 32'h0);
        chk("mr_valid",   {31'h0, Dato_Valido}, 32'h0);
        chk("mr_ovf",     {31'h0, Overflow}, 32'h0);
        chk("mr_perdido", {31'h0, Perdido}, 32'h0);
        chk("mr_ocupado", {31'h0, Ocupado}, 32'h0);
        chk("mr_dir",     {29'h0, Dir_Coef}, 32'h0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK);
            #1;
            if (Dato_Valido) pulses++;
        end
        chk("mr_no_valid", 32'(pulses), 32'h0);
        do_sample(24'h020000, 0, 24'h0, res, ovf, lat, one_cycle);
        chk("mr_after_lat",   32'(lat), 32'd9);
        chk("mr_after_trunc", {8'h0, res}, 32'h020000);
        chk("mr_after_ovf",   {31'h0, ovf}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
